// File: rtl/mode_sched_if.sv
// Frame-sync, block-classification and mode-output bundle for mode_sched.
// N must match HBLKS*VBLKS of the attached scheduler so that lcnt_o has the right width.
interface mode_sched_if #(
  parameter int N = 100
) ();
  localparam int CW = $clog2(N + 1);

  logic          vs_i;
  logic          blk_valid_i;
  logic          blk_i;
  logic [1:0]    mode_i;
  logic          dl_o;
  logic          ld_o;
  logic [1:0]    state_o;
  logic [CW-1:0] lcnt_o;

  modport master (
    output vs_i, blk_valid_i, blk_i, mode_i,
    input  dl_o, ld_o, state_o, lcnt_o
  );

  modport slave (
    input  vs_i, blk_valid_i, blk_i, mode_i,
    output dl_o, ld_o, state_o, lcnt_o
  );
endinterface

// File: rtl/mode_sched.sv
// Per-frame light/dark vote with hysteresis, streak filtering and hold-off,
// producing the smoother's invert targets; forced modes override at frame boundaries.
module mode_sched #(
  parameter int HBLKS  = 10,
  parameter int VBLKS  = 10,
  parameter int TH_HI  = 60,
  parameter int TH_LO  = 40,
  parameter int STABLE = 3,
  parameter int HOLD   = 120
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  mode_sched_if.slave  bus
);
  localparam int N  = HBLKS * VBLKS;
  localparam int CW = $clog2(N + 1);
  localparam int SW = $clog2(STABLE + 1);
  localparam int HW = $clog2(HOLD + 2);

  typedef enum logic [1:0] {PASS = 2'b00, DARK = 2'b01, LIGHT = 2'b10} st_t;

  st_t           state, state_nxt, cand, cand_nxt;
  logic [SW-1:0] streak, streak_nxt;
  logic [HW-1:0] hold, hold_nxt;
  logic [CW-1:0] tot, tot_nxt, lcnt, lcnt_nxt, lcnt_last, lcnt_last_nxt;
  logic          vs_q, dl, ld, dl_nxt, ld_nxt;
  logic          frame_edge, frame_ok, strobe, light;
  st_t           vote, forced;

  function automatic logic [CW-1:0] sat_cnt(input logic [CW-1:0] v);
    return (v >= CW'(N)) ? v : v + 1'b1;
  endfunction

  function automatic logic [SW-1:0] sat_streak(input logic [SW-1:0] v);
    return (v >= SW'(STABLE)) ? v : v + 1'b1;
  endfunction

  // Counts strictly inside (TH_LO, TH_HI) keep the current state.
  function automatic st_t vote_of(input logic [CW-1:0] l, input st_t cur);
    if (l >= CW'(TH_HI)) return LIGHT;
    if (l <= CW'(TH_LO)) return DARK;
    return cur;
  endfunction

  function automatic st_t mode_state(input logic [1:0] m);
    case (m)
      2'b01:   return DARK;
      2'b10:   return LIGHT;
      default: return PASS;
    endcase
  endfunction

  assign frame_edge = bus.vs_i & ~vs_q;
  assign frame_ok   = (tot == CW'(N));
  assign strobe     = bus.blk_valid_i;
  assign light      = bus.blk_valid_i & bus.blk_i;
  assign vote       = vote_of(lcnt, state);
  assign forced     = mode_state(bus.mode_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vs_q      <= 1'b1;
      state     <= PASS;
      cand      <= PASS;
      streak    <= '0;
      hold      <= '0;
      tot       <= '0;
      lcnt      <= '0;
      lcnt_last <= '0;
      dl        <= 1'b0;
      ld        <= 1'b1;
    end else begin
      vs_q      <= bus.vs_i;
      state     <= state_nxt;
      cand      <= cand_nxt;
      streak    <= streak_nxt;
      hold      <= hold_nxt;
      tot       <= tot_nxt;
      lcnt      <= lcnt_nxt;
      lcnt_last <= lcnt_last_nxt;
      dl        <= dl_nxt;
      ld        <= ld_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cand_nxt      = cand;
    streak_nxt    = streak;
    hold_nxt      = hold;
    tot_nxt       = tot;
    lcnt_nxt      = lcnt;
    lcnt_last_nxt = lcnt_last;
    if (frame_edge) begin
      // A strobe coincident with the boundary belongs to the new frame.
      tot_nxt  = CW'(strobe);
      lcnt_nxt = CW'(light);
      hold_nxt = (hold == '0) ? hold : hold - 1'b1;
      if (frame_ok) lcnt_last_nxt = lcnt;
      if (bus.mode_i != 2'b00) begin
        state_nxt  = forced;
        streak_nxt = '0;
        if (forced != state) hold_nxt = HW'(HOLD);
      end else if (frame_ok) begin
        if (vote == state) begin
          streak_nxt = '0;
        end else if (vote == cand) begin
          streak_nxt = sat_streak(streak);
        end else begin
          cand_nxt   = vote;
          streak_nxt = SW'(1);
        end
        // A blocked commit keeps the streak saturated until hold runs out.
        if (streak_nxt >= SW'(STABLE) && hold == '0) begin
          state_nxt  = cand_nxt;
          streak_nxt = '0;
          hold_nxt   = HW'(HOLD);
        end
      end
    end else begin
      if (strobe) tot_nxt  = sat_cnt(tot);
      if (light)  lcnt_nxt = sat_cnt(lcnt);
    end
  end

  always_comb begin
    dl_nxt = 1'b0;
    ld_nxt = 1'b1;
    case (state_nxt)
      DARK:    ld_nxt = 1'b0;
      LIGHT:   dl_nxt = 1'b1;
      default: ;
    endcase
  end

  assign bus.state_o = state;
  assign bus.dl_o    = dl;
  assign bus.ld_o    = ld;
  assign bus.lcnt_o  = lcnt_last;
endmodule

// File: tb/tb_mode_sched.sv
// Directed-vector bench for mode_sched: frame tables with hand-computed results
// plus sequences for hold expiry, forced modes and mid-frame reset.
module tb_mode_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  mode_sched_if #(.N(100)) bus ();

  mode_sched #(
    .HBLKS(10), .VBLKS(10), .TH_HI(60), .TH_LO(40), .STABLE(3), .HOLD(120)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst;
    bit se;
    bit sl;
    int nl;
    int nt;
    int est;
    int elc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rst, input bit se, input bit sl, input int nl,
                     input int nt, input int est, input int elc);
    vec_t v;
    v.rst = rst; v.se = se; v.sl = sl; v.nl = nl; v.nt = nt; v.est = est; v.elc = elc;
    tbl.push_back(v);
  endtask

  task automatic chk(input string tag, input string what, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d, expected %0d", tag, what, act, exp);
    end
  endtask

  // PASS -> dl=0 ld=1, DARK -> dl=0 ld=0, LIGHT -> dl=1 ld=1
  task automatic check_out(input string tag, input int est, input int elc);
    chk(tag, "state", int'(bus.state_o), est);
    chk(tag, "dl", int'(bus.dl_o), (est == 2) ? 1 : 0);
    chk(tag, "ld", int'(bus.ld_o), (est == 1) ? 0 : 1);
    chk(tag, "lcnt", int'(bus.lcnt_o), elc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.vs_i = 1'b0; bus.blk_valid_i = 1'b0; bus.blk_i = 1'b0; bus.mode_i = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge; drives nt strobes, the first nl of them light.
  task automatic strobes(input int nl, input int nt);
    for (int i = 0; i < nt; i++) begin
      bus.blk_valid_i = 1'b1;
      bus.blk_i = (i < nl);
      @(negedge clk);
    end
    bus.blk_valid_i = 1'b0;
    bus.blk_i = 1'b0;
  endtask

  // One boundary (optionally with a coincident strobe) followed by the frame's strobes.
  task automatic frame(input bit se, input bit sl, input int nl, input int nt);
    @(negedge clk);
    bus.vs_i = 1'b1; bus.blk_valid_i = se; bus.blk_i = sl;
    @(negedge clk);
    bus.vs_i = 1'b0; bus.blk_valid_i = 1'b0; bus.blk_i = 1'b0;
    strobes(nl, nt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    bus.vs_i = 1'b0; bus.blk_valid_i = 1'b0; bus.blk_i = 1'b0; bus.mode_i = 2'b00;

    // Each row: its boundary closes the previous row's frame; expectations are
    // the outputs right after that boundary.
    // Alternating 70/30 never builds a streak; then three 70s commit LIGHT.
    add(1,0,0, 70,100, 0,  0);
    add(0,0,0, 30,100, 0, 70);
    add(0,0,0, 70,100, 0, 30);
    add(0,0,0, 30,100, 0, 70);
    add(0,0,0, 70,100, 0, 30);
    add(0,0,0, 30,100, 0, 70);
    add(0,0,0, 70,100, 0, 30);
    add(0,0,0, 30,100, 0, 70);
    add(0,0,0, 70,100, 0, 30);
    add(0,0,0, 30,100, 0, 70);
    add(0,0,0, 70,100, 0, 30);
    add(0,0,0, 70,100, 0, 70);
    add(0,0,0, 70,100, 0, 70);
    add(0,0,0, 50,100, 2, 70);
    // 99-strobe frame, 100th strobe on the boundary, then counter saturation.
    add(0,0,0, 50, 99, 2, 50);
    add(0,0,0, 20, 99, 2, 50);
    add(0,1,1,  0, 99, 2, 50);
    add(0,0,0,105,105, 2,  1);
    add(0,0,0,  0,100, 2,100);
    // Exact thresholds commit; values just inside the band do not.
    add(1,0,0, 60,100, 0,  0);
    add(0,0,0, 60,100, 0, 60);
    add(0,0,0, 60,100, 0, 60);
    add(0,0,0, 41,100, 2, 60);
    add(1,0,0, 40,100, 0,  0);
    add(0,0,0, 40,100, 0, 40);
    add(0,0,0, 40,100, 0, 40);
    add(0,0,0, 41,100, 1, 40);
    add(1,0,0, 59,100, 0,  0);
    add(0,0,0, 41,100, 0, 59);
    add(0,0,0, 59,100, 0, 41);
    add(0,0,0, 41,100, 0, 59);
    add(0,0,0,  0,100, 0, 41);
    // Commit LIGHT, band frames, then dark frames blocked by hold.
    add(1,0,0, 70,100, 0,  0);
    add(0,0,0, 70,100, 0, 70);
    add(0,0,0, 70,100, 0, 70);
    add(0,0,0, 50,100, 2, 70);
    add(0,0,0, 50,100, 2, 50);
    add(0,0,0, 30,100, 2, 50);
    add(0,0,0, 30,100, 2, 30);
    add(0,0,0, 30,100, 2, 30);

    do_reset();
    @(negedge clk);
    check_out("reset", 0, 0);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      frame(tbl[i].se, tbl[i].sl, tbl[i].nl, tbl[i].nt);
      check_out($sformatf("row%0d", i), tbl[i].est, tbl[i].elc);
    end

    // Hold is 116 after the last row; the 117th further dark frame commits DARK.
    k = 0;
    while (k < 200 && bus.state_o == 2'b10) begin
      frame(0, 0, 30, 100);
      k++;
    end
    chk("hold_expiry", "frames", k, 117);
    check_out("dark_commit", 1, 30);

    // Forced modes take effect only at the next boundary, regardless of hold.
    frame(0, 0, 30, 50);
    check_out("auto_keep", 1, 30);
    bus.mode_i = 2'b10;
    repeat (3) @(negedge clk);
    check_out("mid_force_l", 1, 30);
    strobes(0, 50);
    frame(0, 0, 30, 100);
    check_out("force_l", 2, 30);
    frame(0, 0, 30, 50);
    bus.mode_i = 2'b01;
    repeat (3) @(negedge clk);
    check_out("mid_force_d", 2, 30);
    strobes(0, 50);
    frame(0, 0, 30, 100);
    check_out("force_d", 1, 30);
    bus.mode_i = 2'b11;
    frame(0, 0, 30, 100);
    check_out("force_p", 0, 30);

    // Mid-frame reset with vs high and a forced mode pending.
    bus.mode_i = 2'b10;
    frame(0, 0, 60, 60);
    check_out("pre_rst", 2, 30);
    rst_n = 1'b0;
    bus.vs_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_out("mid_rst", 0, 0);
    bus.mode_i = 2'b00;
    strobes(60, 60);
    bus.vs_i = 1'b0;
    @(negedge clk);
    frame(0, 0, 0, 0);
    check_out("post_rst_frame", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
